puf_tmv_gen: RTL
================

Name: puf_tmv_gen

Overview:
- Parametrised, sequenced successor to the wide PUF response generator.
- Drives one external PUF segment bank at a time (SEG_WIDTH raw bits), evaluating each segment VOTES times with temporal majority voting.
- Assembles a stable NUM_SEG*SEG_WIDTH response and reports the number of unstable bits.
- Sits between the PUF segment array and the key-derivation / root-of-trust logic.

Parameters:
SEG_WIDTH, 256, raw bits returned by one PUF segment per evaluation
NUM_SEG, 4, number of segments; response width = NUM_SEG*SEG_WIDTH (default 1024)
VOTES, 5, evaluations per segment; must be odd and >=1 (even value is an elaboration error)
SETTLE_CYCLES, 4, cycles puf_enable is held high before each sample; must be >=1

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  request a new response generation
control_input  input  2  PUF challenge/mode; latched when start is accepted
puf_enable  output  1  enable to the selected PUF segment
puf_control  output  2  latched control_input forwarded to the PUF
puf_seg_sel  output  max(1,clog2(NUM_SEG))  index of the segment being evaluated
puf_raw  input  SEG_WIDTH  raw response of the selected segment
busy  output  1  generation in progress
resp_valid  output  1  response and unstable_cnt are valid
response  output  NUM_SEG*SEG_WIDTH  voted response; segment i at [i*SEG_WIDTH +: SEG_WIDTH]
unstable_cnt  output  clog2(NUM_SEG*SEG_WIDTH+1)  count of bits whose votes were not unanimous

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset (sync, active-high, any state): state=IDLE; puf_enable=0, puf_control=0, puf_seg_sel=0, busy=0, resp_valid=0, response=0, unstable_cnt=0; per-bit vote counters and vote index cleared. Reset mid-generation aborts immediately; no partial response is exposed.
- States: IDLE, SETTLE, SAMPLE, RELAX, COMMIT, DONE.
- IDLE/DONE + start=1: latch control_input into puf_control; seg=0, vote=0; clear counters and unstable_cnt; resp_valid<=0, busy<=1; go to SETTLE. start in any other state is ignored, and control_input changes there have no effect.
- SETTLE: puf_enable=1; lasts exactly SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE (1 cycle): puf_enable=1; at the clock edge, counter[b] += puf_raw[b] for every b; vote++. If vote is now < VOTES, go to RELAX, otherwise go to COMMIT.
- RELAX (1 cycle): puf_enable=0; then SETTLE. Each vote is a fresh power-up.
- COMMIT (1 cycle): puf_enable=0.
  - response[seg*SEG_WIDTH+b] <= (counter[b] > VOTES/2).
  - unstable_cnt += number of b with counter[b] != 0 and counter[b] != VOTES.
  - Counters and vote are cleared.
  - If seg == NUM_SEG-1, go to DONE; otherwise seg++ (puf_seg_sel follows) and go to SETTLE.
- DONE: busy=0, resp_valid=1, puf_enable=0. response and unstable_cnt are held until the next accepted start or reset.
- Counters: width clog2(VOTES+1); they never overflow.
- Latency: per segment, VOTES*(SETTLE_CYCLES+2) cycles. resp_valid rises exactly NUM_SEG*VOTES*(SETTLE_CYCLES+2) clock edges after the edge that accepted start (default: 120).
- puf_seg_sel is stable for the whole evaluation of a segment and changes only at a COMMIT edge.
- response bits of segments not yet committed read 0 while busy.
- VOTES=1: no RELAX state is visited, and unstable_cnt is always 0.
- Simultaneous rst and start: rst wins.

Test Plan:
- Constant source: puf_raw=256'hA5..A5 for all segments, start pulse, defaults -> resp_valid at edge +120; response = {4{256'hA5..A5}}; unstable_cnt=0; puf_enable toggles low 4 times per segment.
- Noisy bit: segment 2 bit 7 reads 1,0,1,1,0 across votes, all other bits 0 -> response[519]=1; unstable_cnt=1; all other response bits 0.
- Minority bit: segment 0 bit 0 reads 1 on 2 of 5 votes -> response[0]=0; unstable_cnt=1.
- start and a control_input change during busy -> both ignored; puf_control keeps its latched value; completion still at edge +120.
- rst asserted at edge +50 -> the next cycle shows busy=0, puf_enable=0, response=0, resp_valid=0; a new start then completes after a full 120 edges.
- Restart from DONE -> resp_valid drops on the accepting edge; unstable_cnt restarts from 0. Separately, with VOTES=1, SETTLE_CYCLES=1, NUM_SEG=2, resp_valid arrives at edge +6.

Source files
------------

// File: rtl/puf_tmv_gen.sv
// ---------------------------------------------------------------------------
// puf_tmv_gen
//   Sequenced PUF response generator with temporal majority voting.
//   Evaluates one external PUF segment bank at a time. Each segment is
//   powered up and sampled VOTES times. A per-bit vote counter then produces
//   a majority bit and flags any bit whose votes were not unanimous. The
//   voted segments are assembled into a NUM_SEG*SEG_WIDTH response.
//
//   Ports
//     clk, rst       clock, synchronous active-high reset
//     start          request a new generation (accepted in IDLE/DONE only)
//     control_input  PUF challenge/mode, latched when start is accepted
//     puf_enable     power/enable to the selected PUF segment
//     puf_control    latched control_input forwarded to the PUF
//     puf_seg_sel    index of the segment under evaluation
//     puf_raw        raw SEG_WIDTH-bit response of the selected segment
//     busy           generation in progress
//     resp_valid     response/unstable_cnt valid (held until next start)
//     response       voted response, segment i at [i*SEG_WIDTH +: SEG_WIDTH]
//     unstable_cnt   number of bits whose votes were not unanimous
// ---------------------------------------------------------------------------

// Per-bit vote lane. Accumulates the number of '1' samples for one raw bit
// and reports majority and instability.
//   clk, rst  clock, synchronous reset
//   clr       clear the vote count (new generation or segment committed)
//   smp       add raw to the count on this edge
//   raw       raw PUF bit
//   maj       count > VOTES/2
//   unst      count is neither 0 nor VOTES
module puf_tmv_lane #(
  parameter int VOTES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic smp,
  input  logic raw,
  output logic maj,
  output logic unst
);
  localparam int CNT_W = $clog2(VOTES + 1);

  // Width CNT_W holds 0..VOTES and at most VOTES samples are taken per
  // segment, so the count cannot wrap.
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (smp)
      cnt <= cnt + CNT_W'(raw);
  end

  assign maj  = (cnt > CNT_W'(VOTES / 2));
  assign unst = (cnt != '0) && (cnt != CNT_W'(VOTES));
endmodule

module puf_tmv_gen #(
  parameter  int SEG_WIDTH     = 256,
  parameter  int NUM_SEG       = 4,
  parameter  int VOTES         = 5,
  parameter  int SETTLE_CYCLES = 4,
  localparam int SEL_W         = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1,
  localparam int UC_W          = $clog2(NUM_SEG * SEG_WIDTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [1:0]                     control_input,
  output logic                           puf_enable,
  output logic [1:0]                     puf_control,
  output logic [SEL_W-1:0]               puf_seg_sel,
  input  logic [SEG_WIDTH-1:0]           puf_raw,
  output logic                           busy,
  output logic                           resp_valid,
  output logic [NUM_SEG*SEG_WIDTH-1:0]   response,
  output logic [UC_W-1:0]                unstable_cnt
);
  localparam int VOTE_W = $clog2(VOTES + 1);
  localparam int ST_W   = $clog2(SETTLE_CYCLES + 1);

  // Parameter legality is checked at elaboration.
  if (VOTES < 1 || (VOTES % 2) == 0) begin : g_bad_votes
    $error("puf_tmv_gen: VOTES must be odd and >= 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("puf_tmv_gen: SETTLE_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    RELAX  = 3'd3,
    COMMIT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                          state, state_nxt;
  logic [ST_W-1:0]                 settle_cnt;
  logic [VOTE_W-1:0]               vote;
  logic [SEL_W-1:0]                seg;
  logic [1:0]                      ctrl_q;
  logic [NUM_SEG-1:0][SEG_WIDTH-1:0] resp_q;
  logic [UC_W-1:0]                 unst_q;

  logic                            start_ok;
  logic                            lane_clr;
  logic                            lane_smp;
  logic [SEG_WIDTH-1:0]            lane_maj;
  logic [SEG_WIDTH-1:0]            lane_unst;
  logic [UC_W-1:0]                 seg_unst;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign lane_clr = start_ok || (state == COMMIT);
  assign lane_smp = (state == SAMPLE);

  // ---------------------------------------------------------------- lanes
  for (genvar b = 0; b < SEG_WIDTH; b++) begin : g_lane
    puf_tmv_lane #(.VOTES(VOTES)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (lane_clr),
      .smp  (lane_smp),
      .raw  (puf_raw[b]),
      .maj  (lane_maj[b]),
      .unst (lane_unst[b])
    );
  end

  // Instability popcount for the segment being committed.
  always_comb begin
    seg_unst = '0;
    for (int b = 0; b < SEG_WIDTH; b++)
      seg_unst = seg_unst + UC_W'(lane_unst[b]);
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    puf_enable = 1'b0;
    busy       = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SETTLE;
      end
      SETTLE: begin
        puf_enable = 1'b1;
        busy       = 1'b1;
        if (settle_cnt == ST_W'(SETTLE_CYCLES - 1)) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        puf_enable = 1'b1;
        busy       = 1'b1;
        // vote still holds the pre-increment value here.
        if (vote == VOTE_W'(VOTES - 1)) state_nxt = COMMIT;
        else                            state_nxt = RELAX;
      end
      RELAX: begin
        // One low cycle so every vote starts from a fresh power-up.
        busy      = 1'b1;
        state_nxt = SETTLE;
      end
      COMMIT: begin
        busy = 1'b1;
        if (seg == SEL_W'(NUM_SEG - 1)) state_nxt = DONE;
        else                            state_nxt = SETTLE;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (start) state_nxt = SETTLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      vote       <= '0;
      seg        <= '0;
      ctrl_q     <= '0;
      resp_q     <= '0;
      unst_q     <= '0;
    end else begin
      // Free-runs only inside SETTLE, so each SETTLE visit starts at 0.
      settle_cnt <= (state == SETTLE) ? settle_cnt + ST_W'(1) : '0;

      if (start_ok) begin
        ctrl_q <= control_input;
        seg    <= '0;
        vote   <= '0;
        resp_q <= '0;
        unst_q <= '0;
      end

      if (state == SAMPLE)
        vote <= vote + VOTE_W'(1);

      if (state == COMMIT) begin
        resp_q[seg] <= lane_maj;
        unst_q      <= unst_q + seg_unst;
        vote        <= '0;
        // seg stays on the last segment in DONE; it is cleared on restart.
        if (seg != SEL_W'(NUM_SEG - 1))
          seg <= seg + SEL_W'(1);
      end
    end
  end

  assign puf_control  = ctrl_q;
  assign puf_seg_sel  = seg;
  assign response     = resp_q;
  assign unstable_cnt = unst_q;
endmodule
